// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, round-robin on
// contention, holding each grant until the memory completes or the wait timer aborts it.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              err,
    output logic              stall
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam bit TIMEOUT_EN = (WAIT_MAX != 0);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state, state_n;
    logic              last_d, last_d_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              m_req_n, m_we_n, i_ack_n, d_ack_n, err_n;
    logic [ADDR_W-1:0] m_addr_n;
    logic [DATA_W-1:0] m_wdata_n, i_rdata_n, d_rdata_n;
    logic              elig_i, elig_d, grant_i, grant_d;

    // A side whose ack is high this cycle is not eligible, so a finished request is never re-granted
    assign elig_i  = i_req & ~i_ack;
    assign elig_d  = d_req & ~d_ack;
    assign grant_i = elig_i & (~elig_d | last_d);
    assign grant_d = elig_d & (~elig_i | ~last_d);
    assign stall   = (i_req & ~i_ack) | (d_req & ~d_ack);

    always_comb begin
        state_n   = state;
        last_d_n  = last_d;
        cnt_n     = cnt;
        m_req_n   = m_req;
        m_we_n    = m_we;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        i_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        err_n     = 1'b0;
        i_rdata_n = i_rdata;
        d_rdata_n = d_rdata;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_n   = BUSY_I;
                    last_d_n  = 1'b0;
                    cnt_n     = '0;
                    m_req_n   = 1'b1;
                    m_we_n    = 1'b0;
                    m_addr_n  = i_addr;
                    m_wdata_n = '0;
                end else if (grant_d) begin
                    state_n   = BUSY_D;
                    last_d_n  = 1'b1;
                    cnt_n     = '0;
                    m_req_n   = 1'b1;
                    m_we_n    = d_we;
                    m_addr_n  = d_addr;
                    m_wdata_n = d_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    state_n = IDLE;
                    m_req_n = 1'b0;
                    if (state == BUSY_I) begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = m_rdata;
                    end else begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = m_rdata;
                    end
                end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                    // Abort: the requester still gets its ack so it can move on, flagged by err
                    state_n = IDLE;
                    m_req_n = 1'b0;
                    err_n   = 1'b1;
                    if (state == BUSY_I) begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = '0;
                    end else begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = '0;
                    end
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state   <= state_n;
            last_d  <= last_d_n;
            cnt     <= cnt_n;
            m_req   <= m_req_n;
            m_we    <= m_we_n;
            m_addr  <= m_addr_n;
            m_wdata <= m_wdata_n;
            i_ack   <= i_ack_n;
            d_ack   <= d_ack_n;
            err     <= err_n;
            i_rdata <= i_rdata_n;
            d_rdata <= d_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, m_req, m_we, err, stall;

    int total_cnt = 0;
    int bad_cnt   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_ready;
        logic [31:0] m_rdata;
        logic        x_stall;
        logic        x_m_req;
        logic        x_m_we;
        logic [31:0] x_m_addr;
        logic [31:0] x_m_wdata;
        logic        x_i_ack;
        logic        x_d_ack;
        logic        x_err;
        logic [31:0] x_i_rdata;
        logic [31:0] x_d_rdata;
    } vec_t;

    vec_t vecs[10];

    // transaction-level reference state for the random run
    bit          txn_open, txn_side, txn_err, txn_we, last_d;
    int          txn_g, txn_ack, txn_ready_cyc, dly;
    logic [31:0] txn_addr, txn_wdata, txn_rdata, exp_i_rdata, exp_d_rdata;
    bit          ack_i_now, ack_d_now, err_now, mreq_exp, el_i, el_d;
    int          grants;
    bit          expect_d;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst) reset_dut();
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        m_ready = v.m_ready; m_rdata = v.m_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // reset values, checked while reset is still held
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
        reset = 1'b1;
        #12;
        checkOutput("rst m_req",   32'(m_req),   32'h0);
        checkOutput("rst m_we",    32'(m_we),    32'h0);
        checkOutput("rst m_addr",  m_addr,       32'h0);
        checkOutput("rst m_wdata", m_wdata,      32'h0);
        checkOutput("rst i_ack",   32'(i_ack),   32'h0);
        checkOutput("rst d_ack",   32'(d_ack),   32'h0);
        checkOutput("rst i_rdata", i_rdata,      32'h0);
        checkOutput("rst d_rdata", d_rdata,      32'h0);
        checkOutput("rst err",     32'(err),     32'h0);

        // I-only fetch, then contention after reset (store on D)
        vecs[0] = '{1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2002000A,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h2002000A, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h2002000A, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h2002000A, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b1, 32'h11111111,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b0, 1'b0, 1'b0, 32'h11111111, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b1, 32'h22222222,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h22222222};
        vecs[9] = '{1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 32'h100, 32'hCAFE, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11111111, 32'h22222222};

        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("vec%0d stall", k), 32'(stall), 32'(vecs[k].x_stall));
            tick();
            checkOutput($sformatf("vec%0d m_req", k),   32'(m_req), 32'(vecs[k].x_m_req));
            checkOutput($sformatf("vec%0d i_ack", k),   32'(i_ack), 32'(vecs[k].x_i_ack));
            checkOutput($sformatf("vec%0d d_ack", k),   32'(d_ack), 32'(vecs[k].x_d_ack));
            checkOutput($sformatf("vec%0d err", k),     32'(err),   32'(vecs[k].x_err));
            checkOutput($sformatf("vec%0d i_rdata", k), i_rdata,    vecs[k].x_i_rdata);
            checkOutput($sformatf("vec%0d d_rdata", k), d_rdata,    vecs[k].x_d_rdata);
            if (vecs[k].x_m_req) begin
                checkOutput($sformatf("vec%0d m_we", k),    32'(m_we), 32'(vecs[k].x_m_we));
                checkOutput($sformatf("vec%0d m_addr", k),  m_addr,    vecs[k].x_m_addr);
                checkOutput($sformatf("vec%0d m_wdata", k), m_wdata,   vecs[k].x_m_wdata);
            end
        end

        // round-robin with both sides requesting continuously
        reset_dut();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        grants = 0;
        expect_d = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            tick();
            m_ready = 0;
            if (m_req) begin
                checkOutput($sformatf("rr grant%0d", grants), m_addr, expect_d ? 32'h2000 : 32'h1000);
                expect_d = !expect_d;
                grants++;
                m_ready = 1;
                m_rdata = $urandom;
            end
        end
        checkOutput("rr grant count", 32'(grants), 32'd6);
        i_req = 0; d_req = 0; m_ready = 0;
        tick();

        // timeout on a load after a normal load, then normal service again
        reset_dut();
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        checkOutput("to first m_req", 32'(m_req), 32'h1);
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        tick();
        checkOutput("to first d_ack", 32'(d_ack), 32'h1);
        checkOutput("to first rdata", d_rdata, 32'hDEADBEEF);
        m_ready = 0; d_addr = 32'h204;
        tick();
        checkOutput("to no regrant on ack", 32'(m_req), 32'h0);
        tick();
        checkOutput("to second m_req", 32'(m_req), 32'h1);
        checkOutput("to second m_addr", m_addr, 32'h204);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("to busy m_req %0d", c), 32'(m_req), 32'h1);
            checkOutput($sformatf("to busy d_ack %0d", c), 32'(d_ack), 32'h0);
        end
        tick();
        checkOutput("to abort d_ack", 32'(d_ack), 32'h1);
        checkOutput("to abort err", 32'(err), 32'h1);
        checkOutput("to abort rdata", d_rdata, 32'h0);
        checkOutput("to abort m_req", 32'(m_req), 32'h0);
        d_addr = 32'h208;
        tick();
        checkOutput("to err pulse", 32'(err), 32'h0);
        checkOutput("to ack pulse", 32'(d_ack), 32'h0);
        tick();
        checkOutput("to retry m_req", 32'(m_req), 32'h1);
        checkOutput("to retry m_addr", m_addr, 32'h208);
        m_ready = 1; m_rdata = 32'h12345678;
        tick();
        checkOutput("to retry d_ack", 32'(d_ack), 32'h1);
        checkOutput("to retry err", 32'(err), 32'h0);
        checkOutput("to retry rdata", d_rdata, 32'h12345678);
        d_req = 0; m_ready = 0;

        // reset while a store is in flight
        reset_dut();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h55;
        tick();
        checkOutput("mid busy m_req", 32'(m_req), 32'h1);
        #2;
        reset = 1'b1;
        m_ready = 1;
        #1;
        checkOutput("mid async m_req", 32'(m_req), 32'h0);
        @(posedge clk);
        #2;
        checkOutput("mid held d_ack", 32'(d_ack), 32'h0);
        checkOutput("mid held err", 32'(err), 32'h0);
        reset = 1'b0;
        m_ready = 0;
        i_req = 1; i_addr = 32'h500;
        tick();
        checkOutput("mid tie to I", m_addr, 32'h500);
        checkOutput("mid tie m_req", 32'(m_req), 32'h1);
        checkOutput("mid no d_ack", 32'(d_ack), 32'h0);

        // spurious m_ready while idle
        reset_dut();
        m_ready = 1; m_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("sp m_req %0d", c), 32'(m_req), 32'h0);
            checkOutput($sformatf("sp acks %0d", c), 32'({i_ack, d_ack, err}), 32'h0);
        end
        m_ready = 0; i_req = 1; i_addr = 32'h600;
        tick();
        checkOutput("sp then grant", 32'(m_req), 32'h1);
        m_ready = 1; m_rdata = 32'h600D;
        tick();
        checkOutput("sp then i_ack", 32'(i_ack), 32'h1);
        checkOutput("sp then i_rdata", i_rdata, 32'h600D);
        i_req = 0; m_ready = 0;

        // randomized run against the transaction model
        reset_dut();
        txn_open = 0; last_d = 1; exp_i_rdata = 0; exp_d_rdata = 0;
        for (int n = 0; n < 3000; n++) begin
            ack_i_now = 0; ack_d_now = 0; err_now = 0;
            if (n > 0) begin
                tick();
                mreq_exp = txn_open && n >= txn_g && n < txn_ack;
                if (txn_open && n == txn_ack) begin
                    if (txn_side) begin
                        ack_d_now = 1;
                        exp_d_rdata = txn_err ? 32'h0 : txn_rdata;
                    end else begin
                        ack_i_now = 1;
                        exp_i_rdata = txn_err ? 32'h0 : txn_rdata;
                    end
                    err_now = txn_err;
                    txn_open = 0;
                end
                checkOutput("rnd m_req",   32'(m_req), 32'(mreq_exp));
                checkOutput("rnd i_ack",   32'(i_ack), 32'(ack_i_now));
                checkOutput("rnd d_ack",   32'(d_ack), 32'(ack_d_now));
                checkOutput("rnd err",     32'(err),   32'(err_now));
                checkOutput("rnd i_rdata", i_rdata,    exp_i_rdata);
                checkOutput("rnd d_rdata", d_rdata,    exp_d_rdata);
                if (mreq_exp && n == txn_g) begin
                    checkOutput("rnd m_addr",  m_addr,    txn_addr);
                    checkOutput("rnd m_we",    32'(m_we), 32'(txn_we));
                    checkOutput("rnd m_wdata", m_wdata,   txn_wdata);
                end
            end
            if (!i_req || ack_i_now) begin
                if (ack_i_now ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
                    i_req = 1; i_addr = $urandom;
                end else begin
                    i_req = 0;
                end
            end
            if (!d_req || ack_d_now) begin
                if (ack_d_now ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                end else begin
                    d_req = 0;
                end
            end
            m_rdata = $urandom;
            if (txn_open && n >= txn_g) begin
                m_ready = (n == txn_ready_cyc);
                if (m_ready) txn_rdata = m_rdata;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            if (!txn_open) begin
                el_i = i_req && !ack_i_now;
                el_d = d_req && !ack_d_now;
                if (el_i || el_d) begin
                    txn_side = (el_i && el_d) ? !last_d : el_d;
                    last_d = txn_side;
                    txn_open = 1;
                    txn_g = n + 1;
                    dly = $urandom_range(0, 5);
                    if (dly < WAIT_MAX) begin
                        txn_ready_cyc = txn_g + dly;
                        txn_ack = txn_g + dly + 1;
                        txn_err = 0;
                    end else begin
                        txn_ready_cyc = -1;
                        txn_ack = txn_g + WAIT_MAX;
                        txn_err = 1;
                    end
                    txn_addr  = txn_side ? d_addr : i_addr;
                    txn_we    = txn_side ? d_we : 1'b0;
                    txn_wdata = txn_side ? d_wdata : 32'h0;
                end
            end
            #1;
            checkOutput("rnd stall", 32'(stall), 32'((i_req && !ack_i_now) || (d_req && !ack_d_now)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
